// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sequences the single unified memory of the multicycle CPU between the CPU
// port and the program-loader/debug port. One access is outstanding at a
// time; simultaneous requests are resolved round-robin. Every access runs
// IDLE (grant) -> ACCESS (RD_LAT or WR_LAT cycles) -> RESP (one-cycle ready
// pulse to the owner) -> IDLE.
//
// Parameters:
//   ADDR_W / DATA_W  address / data width of all ports
//   RD_LAT / WR_LAT  ACCESS cycles for a read / write (legal range 1..15)
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata           CPU request port (req held until cpu_ready)
//   cpu_rdata, cpu_ready            registered CPU read data, completion pulse
//   ldr_req/we/addr/wdata           loader request port, same meaning
//   ldr_rdata, ldr_ready            registered loader read data, completion pulse
//   mem_en, mem_we                  memory enable (ACCESS) / write enable
//   mem_addr, mem_wdata             latched address / write data
//   mem_rdata                       memory read data, valid on last ACCESS cycle
//   busy                            high whenever not IDLE
//   owner                           current or last grant: 0 = CPU, 1 = loader
//   cpu_wait_cnt                    CPU stall counter
//
// Configuration:
//   MEM_ARB_PERF_EN  when defined, cpu_wait_cnt counts cycles with cpu_req high
//                    and cpu_ready low, saturating at 16'hFFFF; otherwise it is
//                    tied to zero.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [15:0]       cpu_wait_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  // Counter preload: ACCESS ends on the cycle the counter reads zero.
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                pick_ldr;

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    // Loader wins when it is alone, or on a tie when the CPU had the last grant.
    pick_ldr     = ldr_req && (!cpu_req || !last_grant_q);

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || ldr_req) begin
          we_d         = pick_ldr ? ldr_we    : cpu_we;
          addr_d       = pick_ldr ? ldr_addr  : cpu_addr;
          wdata_d      = pick_ldr ? ldr_wdata : cpu_wdata;
          owner_d      = pick_ldr;
          last_grant_d = pick_ldr;
          cnt_d        = (pick_ldr ? ldr_we : cpu_we) ? WR_CNT : RD_CNT;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the read-data registers are reset too, so a reset mid-access leaves
  // no stale data visible to either requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (state_q == ST_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == ST_RESP) && !owner_q;
  assign ldr_ready = (state_q == ST_RESP) &&  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cpu_req && !cpu_ready && (wait_cnt_q != 16'hFFFF))
      wait_cnt_d = wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign cpu_wait_cnt = wait_cnt_q;
`else
  assign cpu_wait_cnt = '0;
`endif

endmodule
